player_ctrl: RTL and testbench

- Consumes debounced button levels and press pulses for LEFT, RIGHT and FIRE.
- Maintains the player ship's horizontal position, with an immediate step on press, then auto-repeat while held.
- Issues fire requests to the bullet engine through a req/ack handshake, followed by a cooldown.
- All timing is counted in frame ticks, not clocks.

---
 rtl/player_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_player_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_ctrl.sv
// Player ship controller: press/auto-repeat movement plus a fire request/ack handshake with cooldown.
// Define MOVE_AUTOREPEAT_EN to build the held-button auto-repeat; otherwise only press pulses move the ship.
module player_ctrl #(
    parameter int X_WIDTH       = 10,
    parameter int X_MIN         = 16,
    parameter int X_MAX         = 600,
    parameter int X_RESET       = 300,
    parameter int STEP          = 4,
    parameter int HOLD_DELAY    = 20,
    parameter int REPEAT_PERIOD = 4,
    parameter int COOLDOWN      = 30,
    parameter int TIMER_WIDTH   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic               left_db,
    input  logic               left_press,
    input  logic               right_db,
    input  logic               right_press,
    input  logic               fire_press,
    input  logic               fire_ack,
    output logic [X_WIDTH-1:0] ship_x,
    output logic               fire_req,
    output logic [X_WIDTH-1:0] fire_x,
    output logic               fire_ready
);

    localparam logic [X_WIDTH-1:0] X_MIN_C   = X_WIDTH'(X_MIN);
    localparam logic [X_WIDTH-1:0] X_MAX_C   = X_WIDTH'(X_MAX);
    localparam logic [X_WIDTH-1:0] X_RESET_C = X_WIDTH'(X_RESET);
    localparam logic [X_WIDTH-1:0] STEP_C    = X_WIDTH'(STEP);
    localparam logic [X_WIDTH-1:0] R_LIMIT   = X_WIDTH'(X_MAX - STEP);
    localparam logic [X_WIDTH-1:0] L_LIMIT   = X_WIDTH'(X_MIN + STEP);
    localparam logic [TIMER_WIDTH-1:0] COOL_C = TIMER_WIDTH'(COOLDOWN);

    // Saturating steps: compare before the add/subtract so the result never wraps.
    function automatic logic [X_WIDTH-1:0] step_right(input logic [X_WIDTH-1:0] x);
        return (x > R_LIMIT) ? X_MAX_C : x + STEP_C;
    endfunction

    function automatic logic [X_WIDTH-1:0] step_left(input logic [X_WIDTH-1:0] x);
        return (x < L_LIMIT) ? X_MIN_C : x - STEP_C;
    endfunction

    logic [X_WIDTH-1:0] ship_x_reg;
    logic               left_only;
    logic               right_only;

    // Simultaneous left and right presses cancel out.
    assign left_only  = left_press & ~right_press;
    assign right_only = right_press & ~left_press;

`ifdef MOVE_AUTOREPEAT_EN
    localparam logic [TIMER_WIDTH-1:0] HOLD_C = TIMER_WIDTH'(HOLD_DELAY);
    localparam logic [TIMER_WIDTH-1:0] REP_C  = TIMER_WIDTH'(REPEAT_PERIOD);

    typedef enum logic [2:0] {
        IDLE,
        L_HOLD,
        L_REP,
        R_HOLD,
        R_REP
    } move_state_t;

    move_state_t            move_state_reg;
    logic [TIMER_WIDTH-1:0] move_timer_reg;
    logic [TIMER_WIDTH-1:0] move_timer_next;

    assign move_timer_next = move_timer_reg + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ship_x_reg     <= X_RESET_C;
            move_state_reg <= IDLE;
            move_timer_reg <= '0;
        end else if (left_only) begin
            ship_x_reg     <= step_left(ship_x_reg);
            move_state_reg <= L_HOLD;
            move_timer_reg <= '0;
        end else if (right_only) begin
            ship_x_reg     <= step_right(ship_x_reg);
            move_state_reg <= R_HOLD;
            move_timer_reg <= '0;
        end else if (!(left_press && right_press)) begin
            case (move_state_reg)
                L_HOLD, L_REP: begin
                    // Releasing the own button or pressing both freezes movement.
                    if (!left_db || right_db) begin
                        move_state_reg <= IDLE;
                        move_timer_reg <= '0;
                    end else if (tick) begin
                        if (move_state_reg == L_HOLD) begin
                            if (move_timer_next == HOLD_C) begin
                                move_state_reg <= L_REP;
                                move_timer_reg <= '0;
                            end else begin
                                move_timer_reg <= move_timer_next;
                            end
                        end else if (move_timer_next == REP_C) begin
                            ship_x_reg     <= step_left(ship_x_reg);
                            move_timer_reg <= '0;
                        end else begin
                            move_timer_reg <= move_timer_next;
                        end
                    end
                end
                R_HOLD, R_REP: begin
                    if (!right_db || left_db) begin
                        move_state_reg <= IDLE;
                        move_timer_reg <= '0;
                    end else if (tick) begin
                        if (move_state_reg == R_HOLD) begin
                            if (move_timer_next == HOLD_C) begin
                                move_state_reg <= R_REP;
                                move_timer_reg <= '0;
                            end else begin
                                move_timer_reg <= move_timer_next;
                            end
                        end else if (move_timer_next == REP_C) begin
                            ship_x_reg     <= step_right(ship_x_reg);
                            move_timer_reg <= '0;
                        end else begin
                            move_timer_reg <= move_timer_next;
                        end
                    end
                end
                default: begin
                    move_state_reg <= IDLE;
                    move_timer_reg <= '0;
                end
            endcase
        end
    end
`else
    // Without auto-repeat the held levels and hold/repeat timing play no part.
    localparam int unused_timing = HOLD_DELAY + REPEAT_PERIOD;
    logic unused_db;
    assign unused_db = left_db ^ right_db;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ship_x_reg <= X_RESET_C;
        end else if (left_only) begin
            ship_x_reg <= step_left(ship_x_reg);
        end else if (right_only) begin
            ship_x_reg <= step_right(ship_x_reg);
        end
    end
`endif

    typedef enum logic [1:0] {
        F_READY,
        F_REQ,
        F_COOL
    } fire_state_t;

    fire_state_t            fire_state_reg;
    logic [TIMER_WIDTH-1:0] fire_timer_reg;
    logic [TIMER_WIDTH-1:0] fire_timer_next;
    logic                   fire_req_reg;
    logic [X_WIDTH-1:0]     fire_x_reg;
    logic                   fire_ready_reg;

    assign fire_timer_next = fire_timer_reg + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fire_state_reg <= F_READY;
            fire_timer_reg <= '0;
            fire_req_reg   <= 1'b0;
            fire_x_reg     <= '0;
            fire_ready_reg <= 1'b1;
        end else begin
            case (fire_state_reg)
                F_READY: begin
                    // ship_x_reg here is the position before any same-cycle step.
                    if (fire_press) begin
                        fire_x_reg     <= ship_x_reg;
                        fire_req_reg   <= 1'b1;
                        fire_ready_reg <= 1'b0;
                        fire_state_reg <= F_REQ;
                    end
                end
                F_REQ: begin
                    if (fire_ack) begin
                        fire_req_reg   <= 1'b0;
                        fire_timer_reg <= '0;
                        fire_state_reg <= F_COOL;
                    end
                end
                F_COOL: begin
                    if (tick) begin
                        if (fire_timer_next == COOL_C) begin
                            fire_timer_reg <= '0;
                            fire_ready_reg <= 1'b1;
                            fire_state_reg <= F_READY;
                        end else begin
                            fire_timer_reg <= fire_timer_next;
                        end
                    end
                end
                default: begin
                    fire_state_reg <= F_READY;
                    fire_req_reg   <= 1'b0;
                    fire_ready_reg <= 1'b1;
                    fire_timer_reg <= '0;
                end
            endcase
        end
    end

    assign ship_x     = ship_x_reg;
    assign fire_req   = fire_req_reg;
    assign fire_x     = fire_x_reg;
    assign fire_ready = fire_ready_reg;

endmodule

// File: tb/tb_player_ctrl.sv
// Self-checking bench for player_ctrl: vector table, fire scoreboard and multi-cycle corner sequences.
module tb_player_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       left_db = 1'b0;
    logic       left_press = 1'b0;
    logic       right_db = 1'b0;
    logic       right_press = 1'b0;
    logic       fire_press = 1'b0;
    logic       fire_ack = 1'b0;
    logic [9:0] ship_x;
    logic       fire_req;
    logic [9:0] fire_x;
    logic       fire_ready;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic       lp;
        logic       rp;
        logic [9:0] exp_x;
    } vec_t;

    vec_t       vecs[6];
    logic [9:0] exp_q[$];

    player_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .left_db    (left_db),
        .left_press (left_press),
        .right_db   (right_db),
        .right_press(right_press),
        .fire_press (fire_press),
        .fire_ack   (fire_ack),
        .ship_x     (ship_x),
        .fire_req   (fire_req),
        .fire_x     (fire_x),
        .fire_ready (fire_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("  ok %s = %0d", name, act);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            step();
        end
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        {tick, left_db, left_press, right_db, right_press, fire_press, fire_ack} = '0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic press(input logic lp, input logic rp);
        left_press  = lp;
        right_press = rp;
        step();
        left_press  = 1'b0;
        right_press = 1'b0;
    endtask

    // Scoreboard pop: wait (bounded) for the request and compare the captured position.
    task automatic expect_fire(input string name);
        logic [9:0] exp;
        int         waited;
        waited = 0;
        while (!fire_req && waited < 4) begin
            step();
            waited++;
        end
        exp = exp_q.pop_front();
        if (!fire_req) begin
            check({name, "_req_timeout"}, 32'(fire_req), 32'd1);
        end else begin
            check({name, "_latency"}, 32'(waited), 32'd0);
            check({name, "_fire_x"}, 32'(fire_x), 32'(exp));
        end
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b1, 10'd304};
        vecs[1] = '{1'b1, 1'b0, 10'd300};
        vecs[2] = '{1'b1, 1'b1, 10'd300};
        vecs[3] = '{1'b0, 1'b0, 10'd300};
        vecs[4] = '{1'b1, 1'b0, 10'd296};
        vecs[5] = '{1'b0, 1'b1, 10'd300};

        // Reset values
        rst_n = 1'b0;
        step();
        check("rst_ship_x", 32'(ship_x), 32'd300);
        check("rst_fire_req", 32'(fire_req), 32'd0);
        check("rst_fire_x", 32'(fire_x), 32'd0);
        check("rst_fire_ready", 32'(fire_ready), 32'd1);
        do_reset();

        // Vector table of single press pulses
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(vecs[i].exp_x);
            press(vecs[i].lp, vecs[i].rp);
            check($sformatf("vec%0d_ship_x", i), 32'(ship_x), 32'(exp_q.pop_front()));
        end

        // Single right press released at once: one step, nothing more
        do_reset();
        right_db = 1'b1;
        press(1'b0, 1'b1);
        right_db = 1'b0;
        check("tap_right_step", 32'(ship_x), 32'd304);
        ticks(100);
        check("tap_right_no_repeat", 32'(ship_x), 32'd304);

        // Held right
        do_reset();
        right_db = 1'b1;
        press(1'b0, 1'b1);
        check("hold_press_step", 32'(ship_x), 32'd304);
`ifdef MOVE_AUTOREPEAT_EN
        for (int k = 1; k <= 32; k++) begin
            ticks(1);
            if (k == 23) check("hold_t23", 32'(ship_x), 32'd304);
            if (k == 24) check("hold_t24", 32'(ship_x), 32'd308);
            if (k == 28) check("hold_t28", 32'(ship_x), 32'd312);
            if (k == 32) check("hold_t32", 32'(ship_x), 32'd316);
        end
        right_db = 1'b0;
        ticks(20);
        check("hold_release_idle", 32'(ship_x), 32'd316);
`else
        ticks(100);
        check("hold_single_step", 32'(ship_x), 32'd304);
        right_db = 1'b0;
`endif

        // Both presses in the same cycle while holding right
        do_reset();
        right_db = 1'b1;
        press(1'b0, 1'b1);
        ticks(10);
        press(1'b1, 1'b1);
        check("both_press_ignored", 32'(ship_x), 32'd304);
`ifdef MOVE_AUTOREPEAT_EN
        ticks(13);
        check("both_press_t23", 32'(ship_x), 32'd304);
        ticks(1);
        check("both_press_state_kept", 32'(ship_x), 32'd308);
        left_db = 1'b1;
        ticks(12);
        check("both_db_freeze", 32'(ship_x), 32'd308);
        left_db = 1'b0;
        ticks(12);
        check("both_db_went_idle", 32'(ship_x), 32'd308);
`endif
        right_db = 1'b0;

        // Clamping at both ends
        do_reset();
        for (int i = 0; i < 71; i++) press(1'b1, 1'b0);
        check("reach_min", 32'(ship_x), 32'd16);
        press(1'b1, 1'b0);
        check("clamp_min", 32'(ship_x), 32'd16);
        left_db = 1'b1;
        press(1'b1, 1'b0);
        ticks(30);
        left_db = 1'b0;
        check("hold_at_min", 32'(ship_x), 32'd16);
        for (int i = 0; i < 146; i++) press(1'b0, 1'b1);
        check("reach_max", 32'(ship_x), 32'd600);
        press(1'b0, 1'b1);
        check("clamp_max", 32'(ship_x), 32'd600);
        step();

        // Fire handshake with a simultaneous move press
        do_reset();
        fire_press = 1'b1;
        exp_q.push_back(10'd300);
        press(1'b0, 1'b1);
        fire_press = 1'b0;
        check("fire_move_together", 32'(ship_x), 32'd304);
        check("fire_ready_drop", 32'(fire_ready), 32'd0);
        expect_fire("fire1");
        for (int c = 0; c < 5; c++) begin
            fire_press = (c == 1);
            right_press = (c == 2);
            step();
            fire_press = 1'b0;
            right_press = 1'b0;
            check($sformatf("req_held_c%0d", c), 32'(fire_req), 32'd1);
            check($sformatf("fire_x_stable_c%0d", c), 32'(fire_x), 32'd300);
        end
        fire_ack = 1'b1;
        step();
        fire_ack = 1'b0;
        check("req_drop_after_ack", 32'(fire_req), 32'd0);
        check("cool_not_ready", 32'(fire_ready), 32'd0);
        fire_press = 1'b1;
        step();
        fire_press = 1'b0;
        step();
        check("cool_press_dropped", 32'(fire_req), 32'd0);
        ticks(29);
        check("cool_t29", 32'(fire_ready), 32'd0);
        ticks(1);
        check("cool_t30_ready", 32'(fire_ready), 32'd1);
        fire_ack = 1'b1;
        step();
        fire_ack = 1'b0;
        check("stray_ack_ready", 32'(fire_ready), 32'd1);
        check("stray_ack_req", 32'(fire_req), 32'd0);
        fire_press = 1'b1;
        exp_q.push_back(10'd308);
        step();
        fire_press = 1'b0;
        expect_fire("fire2");
        fire_ack = 1'b1;
        step();
        fire_ack = 1'b0;

        // Asynchronous reset during an outstanding request while moving left
        do_reset();
        left_db = 1'b1;
        press(1'b1, 1'b0);
`ifdef MOVE_AUTOREPEAT_EN
        ticks(25);
        check("lrep_step", 32'(ship_x), 32'd292);
`endif
        fire_press = 1'b1;
        step();
        fire_press = 1'b0;
        check("pre_rst_req", 32'(fire_req), 32'd1);
        rst_n = 1'b0;
        #2;
        check("async_rst_req", 32'(fire_req), 32'd0);
        check("async_rst_ship_x", 32'(ship_x), 32'd300);
        check("async_rst_ready", 32'(fire_ready), 32'd1);
        check("async_rst_fire_x", 32'(fire_x), 32'd0);
        left_db = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
